// File: rtl/stage_decode_queue_pkg.sv
// Shared types for the decode queue: fetch lane, decoded record (RS/ROB/RAT
// views), opcode constants and the ALU function helper.
package stage_decode_queue_pkg;

  localparam int unsigned DQ_WIDTH = 2;   // default decode/dispatch width
  localparam int unsigned DQ_DEPTH = 16;  // default queue capacity

  localparam logic [4:0]  ZERO_REG = 5'd0;
  localparam logic [31:0] WFI_INST = 32'h1050_0073;  // treated as halt

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_IMM    = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_REG    = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6f;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLT  = 4'd2,
    ALU_SLTU = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_func_e;

  // One fetched lane
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
  } if_id_t;

  // Reservation-station view of a decoded instruction
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] imm;
    alu_func_e   func;
    logic        opb_is_imm;
    logic [4:0]  op1_arn;
    logic [4:0]  op2_arn;
    logic [4:0]  dest_arn;
    logic        rd_mem;
    logic        wr_mem;
    logic        cond_branch;
    logic        uncond_branch;
    logic        halt;
    logic        illegal;
  } rs_packet_t;

  // Reorder-buffer allocation fields
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  dest_arn;
    logic        halt;
    logic        illegal;
  } rob_entry_t;

  // Rename-table lookup/allocation fields
  typedef struct packed {
    logic       valid;
    logic [4:0] op1_arn;
    logic [4:0] op2_arn;
    logic [4:0] dest_arn;
  } rat_in_t;

  // Stored queue entry and output lane
  typedef struct packed {
    rs_packet_t rs;
    rob_entry_t rob;
    rat_in_t    rat;
  } decoded_inst_t;

  // ALU op from funct3; alt selects SUB/SRA
  function automatic alu_func_e alu_func(input logic [2:0] f3, input logic alt);
    alu_func_e f;
    case (f3)
      3'd0:    f = alt ? ALU_SUB : ALU_ADD;
      3'd1:    f = ALU_SLL;
      3'd2:    f = ALU_SLT;
      3'd3:    f = ALU_SLTU;
      3'd4:    f = ALU_XOR;
      3'd5:    f = alt ? ALU_SRA : ALU_SRL;
      3'd6:    f = ALU_OR;
      default: f = ALU_AND;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/stage_decode_queue_decoder.sv
// Combinational RV32I decoder for one fetch lane.
//   fetch   : fetched lane (valid, pc, inst)
//   decoded : decoded record with RS/ROB/RAT fields; valids follow fetch.valid
module stage_decode_queue_decoder
  import stage_decode_queue_pkg::*;
(
  input  if_id_t        fetch,
  output decoded_inst_t decoded
);

  logic [31:0] inst;
  logic [6:0]  opcode;
  logic        uses_rs1;
  logic        uses_rs2;
  logic        has_dest;
  logic [31:0] imm;
  alu_func_e   func;
  logic        opb_is_imm;
  logic        rd_mem;
  logic        wr_mem;
  logic        cond_branch;
  logic        uncond_branch;
  logic        halt;
  logic        illegal;
  logic [4:0]  op1_arn;
  logic [4:0]  op2_arn;
  logic [4:0]  dest_arn;

  assign inst   = fetch.inst;
  assign opcode = inst[6:0];

  // Opcode classification and immediate formation
  always_comb begin
    uses_rs1      = 1'b0;
    uses_rs2      = 1'b0;
    has_dest      = 1'b0;
    imm           = '0;
    func          = ALU_ADD;
    opb_is_imm    = 1'b0;
    rd_mem        = 1'b0;
    wr_mem        = 1'b0;
    cond_branch   = 1'b0;
    uncond_branch = 1'b0;
    halt          = 1'b0;
    illegal       = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        has_dest   = 1'b1;
        imm        = {inst[31:12], 12'b0};
        opb_is_imm = 1'b1;
      end
      OPC_JAL: begin
        has_dest      = 1'b1;
        uncond_branch = 1'b1;
        imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      OPC_JALR: begin
        uses_rs1      = 1'b1;
        has_dest      = 1'b1;
        uncond_branch = 1'b1;
        imm = {{20{inst[31]}}, inst[31:20]};
      end
      OPC_BRANCH: begin
        uses_rs1    = 1'b1;
        uses_rs2    = 1'b1;
        cond_branch = 1'b1;
        imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      OPC_LOAD: begin
        uses_rs1   = 1'b1;
        has_dest   = 1'b1;
        rd_mem     = 1'b1;
        opb_is_imm = 1'b1;
        imm = {{20{inst[31]}}, inst[31:20]};
      end
      OPC_STORE: begin
        uses_rs1   = 1'b1;
        uses_rs2   = 1'b1;
        wr_mem     = 1'b1;
        opb_is_imm = 1'b1;
        imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      OPC_IMM: begin
        uses_rs1   = 1'b1;
        has_dest   = 1'b1;
        opb_is_imm = 1'b1;
        imm  = {{20{inst[31]}}, inst[31:20]};
        // only shifts use bit 30 as a modifier; addi with a negative imm must stay ADD
        func = alu_func(inst[14:12], (inst[14:12] == 3'd5) && inst[30]);
      end
      OPC_REG: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        has_dest = 1'b1;
        func     = alu_func(inst[14:12], inst[30]);
      end
      OPC_SYSTEM: begin
        if (inst == WFI_INST) halt = 1'b1;
        else                  illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  // Unused operands and missing destinations read/write the zero register
  assign op1_arn  = uses_rs1 ? inst[19:15] : ZERO_REG;
  assign op2_arn  = uses_rs2 ? inst[24:20] : ZERO_REG;
  assign dest_arn = has_dest ? inst[11:7]  : ZERO_REG;

  // Record assembly
  always_comb begin
    decoded                  = '0;
    decoded.rs.valid         = fetch.valid;
    decoded.rs.pc            = fetch.pc;
    decoded.rs.inst          = inst;
    decoded.rs.imm           = imm;
    decoded.rs.func          = func;
    decoded.rs.opb_is_imm    = opb_is_imm;
    decoded.rs.op1_arn       = op1_arn;
    decoded.rs.op2_arn       = op2_arn;
    decoded.rs.dest_arn      = dest_arn;
    decoded.rs.rd_mem        = rd_mem;
    decoded.rs.wr_mem        = wr_mem;
    decoded.rs.cond_branch   = cond_branch;
    decoded.rs.uncond_branch = uncond_branch;
    decoded.rs.halt          = halt;
    decoded.rs.illegal       = illegal;
    decoded.rob.valid        = fetch.valid;
    decoded.rob.pc           = fetch.pc;
    decoded.rob.dest_arn     = dest_arn;
    decoded.rob.halt         = halt;
    decoded.rob.illegal      = illegal;
    decoded.rat.valid        = fetch.valid;
    decoded.rat.op1_arn      = op1_arn;
    decoded.rat.op2_arn      = op2_arn;
    decoded.rat.dest_arn     = dest_arn;
  end

endmodule

// File: rtl/stage_decode_queue.sv
// Decode queue: decodes up to N fetched lanes per cycle, compacts the valid
// ones into a circular buffer and presents the N oldest entries downstream.
//   clock, reset    : clock and asynchronous active-low reset
//   squash          : flush all queued entries
//   if_id_packet    : N fetched lanes, each with its own valid bit
//   in_ready        : queue accepts this cycle's if_id_packet
//   dispatch_count  : head entries consumed downstream this cycle
//   id_ooo_packet   : N oldest decoded entries with per-lane valids
//   count           : current occupancy
// DEPTH must be at least 2*N.
module stage_decode_queue
  import stage_decode_queue_pkg::*;
#(
  parameter int unsigned N     = DQ_WIDTH,
  parameter int unsigned DEPTH = DQ_DEPTH
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       squash,
  input  if_id_t [N-1:0]             if_id_packet,
  output logic                       in_ready,
  input  logic [$clog2(N+1)-1:0]     dispatch_count,
  output decoded_inst_t [N-1:0]      id_ooo_packet,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned LANE_W = $clog2(N+1);
  localparam int unsigned CNT_W  = $clog2(DEPTH+1);

  // Advance a pointer by at most N, wrapping for any DEPTH
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                input logic [LANE_W-1:0] inc);
    logic [PTR_W:0] sum;
    sum = {1'b0, base} + (PTR_W+1)'(inc);
    if (sum >= (PTR_W+1)'(DEPTH)) sum = sum - (PTR_W+1)'(DEPTH);
    return sum[PTR_W-1:0];
  endfunction

  decoded_inst_t      mem [DEPTH];
  decoded_inst_t      dec [N];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [PTR_W-1:0]   head_n;
  logic [PTR_W-1:0]   tail_n;
  logic [CNT_W-1:0]   count_n;
  logic               in_ready_n;
  logic [LANE_W-1:0]  offs [N];
  logic [LANE_W-1:0]  enq_avail;
  logic [LANE_W-1:0]  enq_cnt;
  logic [LANE_W-1:0]  deq_cnt;
  logic               accept;
  logic [DEPTH-1:0]   wr_en;
  decoded_inst_t      wr_data [DEPTH];

  // One decoder per input lane; decode happens before storage
  for (genvar i = 0; i < N; i++) begin : g_dec
    stage_decode_queue_decoder u_dec (
      .fetch   (if_id_packet[i]),
      .decoded (dec[i])
    );
  end

  // Exclusive prefix sum of lane valids gives each lane's slot offset from tail
  always_comb begin : prefix_sum
    logic [LANE_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < N; i++) begin
      offs[i] = acc;
      acc     = acc + LANE_W'(if_id_packet[i].valid);
    end
    enq_avail = acc;
  end

  assign accept  = in_ready && !squash;
  assign enq_cnt = accept ? enq_avail : '0;

  // Dequeue is clamped to occupancy and to the output width
  always_comb begin : deq_clamp
    logic [CNT_W-1:0] d;
    d = CNT_W'(dispatch_count);
    if (d > count)        d = count;
    if (d > CNT_W'(N))    d = CNT_W'(N);
    deq_cnt = squash ? '0 : LANE_W'(d);
  end

  // Scatter compacted lanes into storage slots
  always_comb begin : scatter
    logic [PTR_W-1:0] idx;
    wr_en = '0;
    idx   = '0;
    for (int e = 0; e < DEPTH; e++) wr_data[e] = '0;
    for (int i = 0; i < N; i++) begin
      if (accept && if_id_packet[i].valid) begin
        idx          = wrap_add(tail, offs[i]);
        wr_en[idx]   = 1'b1;
        wr_data[idx] = dec[i];
      end
    end
  end

  // Entry storage is not reset; count masks stale contents
  always_ff @(posedge clock) begin
    for (int e = 0; e < DEPTH; e++) begin
      if (wr_en[e]) mem[e] <= wr_data[e];
    end
  end

  // Pointer and occupancy next state
  always_comb begin
    head_n  = wrap_add(head, deq_cnt);
    tail_n  = wrap_add(tail, enq_cnt);
    count_n = count + CNT_W'(enq_cnt) - CNT_W'(deq_cnt);
    if (squash) begin
      head_n  = '0;
      tail_n  = '0;
      count_n = '0;
    end
    // readiness reflects the registered count only, never a same-cycle dequeue
    in_ready_n = (32'(count_n) <= DEPTH - N);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      in_ready <= 1'b1;
    end else begin
      head     <= head_n;
      tail     <= tail_n;
      count    <= count_n;
      in_ready <= in_ready_n;
    end
  end

  // Output lane i shows entry head+i; valids beyond occupancy are forced low
  always_comb begin
    for (int i = 0; i < N; i++) begin
      logic lane_valid;
      lane_valid                 = CNT_W'(i) < count;
      id_ooo_packet[i]           = mem[wrap_add(head, LANE_W'(i))];
      id_ooo_packet[i].rs.valid  = lane_valid;
      id_ooo_packet[i].rob.valid = lane_valid;
      id_ooo_packet[i].rat.valid = lane_valid;
    end
  end

endmodule

// File: tb/tb_stage_decode_queue.sv
// Directed bench for stage_decode_queue with N=2, DEPTH=8.
module tb_stage_decode_queue;
  import stage_decode_queue_pkg::*;

  logic                clock;
  logic                reset;
  logic                squash;
  if_id_t [1:0]        if_id;
  logic                in_ready;
  logic [1:0]          dispatch_count;
  decoded_inst_t [1:0] ooo;
  logic [3:0]          count;

  int errors;
  int checks;

  stage_decode_queue #(.N(2), .DEPTH(8)) dut (
    .clock          (clock),
    .reset          (reset),
    .squash         (squash),
    .if_id_packet   (if_id),
    .in_ready       (in_ready),
    .dispatch_count (dispatch_count),
    .id_ooo_packet  (ooo),
    .count          (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic if_id_t mk_lane(input logic v, input logic [31:0] inst,
                                     input logic [31:0] pc);
    if_id_t l;
    l.valid = v;
    l.inst  = inst;
    l.pc    = pc;
    return l;
  endfunction

  // addi xrd, x0, rd
  function automatic logic [31:0] mk_addi(input int unsigned rd);
    logic [31:0] r;
    r = {12'(rd), 5'd0, 3'b000, 5'(rd), 7'h13};
    return r;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    if_id[0] = mk_lane(1'b0, 32'h0, 32'h0);
    if_id[1] = mk_lane(1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    #12;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if ({ooo[1].rs.valid, ooo[0].rs.valid} !== 2'b00) begin errors++; $display("FAIL reset_valid: got %b want 00", {ooo[1].rs.valid, ooo[0].rs.valid}); end
    reset = 1'b1;
  endtask

  task automatic test_basic();
    if_id[0] = mk_lane(1'b1, 32'h0051_0093, 32'h100);  // addi x1, x2, 5
    if_id[1] = mk_lane(1'b1, 32'h0041_8133, 32'h104);  // add  x2, x3, x4
    dispatch_count = 2'd0;
    step();
    checks++; if (count !== 4'd2) begin errors++; $display("FAIL basic_count: got %0d want 2", count); end
    checks++; if ({ooo[1].rs.valid, ooo[0].rs.valid} !== 2'b11) begin errors++; $display("FAIL basic_valid: got %b want 11", {ooo[1].rs.valid, ooo[0].rs.valid}); end
    checks++; if (ooo[0].rs.dest_arn !== 5'd1) begin errors++; $display("FAIL basic_dest0: got %0d want 1", ooo[0].rs.dest_arn); end
    checks++; if (ooo[1].rs.dest_arn !== 5'd2) begin errors++; $display("FAIL basic_dest1: got %0d want 2", ooo[1].rs.dest_arn); end
    checks++; if (ooo[0].rs.op1_arn !== 5'd2 || ooo[0].rs.op2_arn !== 5'd0) begin errors++; $display("FAIL basic_ops0: got %0d/%0d want 2/0", ooo[0].rs.op1_arn, ooo[0].rs.op2_arn); end
    checks++; if (ooo[1].rat.op1_arn !== 5'd3 || ooo[1].rat.op2_arn !== 5'd4) begin errors++; $display("FAIL basic_ops1: got %0d/%0d want 3/4", ooo[1].rat.op1_arn, ooo[1].rat.op2_arn); end
    checks++; if (ooo[0].rs.imm !== 32'd5 || ooo[0].rs.opb_is_imm !== 1'b1) begin errors++; $display("FAIL basic_imm: got %0d/%b want 5/1", ooo[0].rs.imm, ooo[0].rs.opb_is_imm); end
    checks++; if (ooo[1].rob.pc !== 32'h104 || ooo[1].rob.valid !== 1'b1) begin errors++; $display("FAIL basic_rob1: got pc %h v %b want 104/1", ooo[1].rob.pc, ooo[1].rob.valid); end
    checks++; if (ooo[1].rs.func !== ALU_ADD) begin errors++; $display("FAIL basic_func1: got %0d want %0d", ooo[1].rs.func, ALU_ADD); end
    idle_inputs();
    dispatch_count = 2'd2;
    step();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL drain_count: got %0d want 0", count); end
    checks++; if (ooo[0].rob.valid !== 1'b0 || ooo[0].rat.valid !== 1'b0) begin errors++; $display("FAIL drain_robrat: got %b/%b want 0/0", ooo[0].rob.valid, ooo[0].rat.valid); end
  endtask

  task automatic test_sparse();
    if_id[0] = mk_lane(1'b0, mk_addi(9), 32'h110);
    if_id[1] = mk_lane(1'b1, mk_addi(7), 32'h114);
    dispatch_count = 2'd0;
    step();
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL sparse_count: got %0d want 1", count); end
    checks++; if ({ooo[1].rs.valid, ooo[0].rs.valid} !== 2'b01) begin errors++; $display("FAIL sparse_valid: got %b want 01", {ooo[1].rs.valid, ooo[0].rs.valid}); end
    checks++; if (ooo[0].rs.dest_arn !== 5'd7 || ooo[0].rs.pc !== 32'h114) begin errors++; $display("FAIL sparse_lane0: got %0d/%h want 7/114", ooo[0].rs.dest_arn, ooo[0].rs.pc); end
    checks++; if (ooo[1].rob.valid !== 1'b0 || ooo[1].rat.valid !== 1'b0) begin errors++; $display("FAIL sparse_lane1_inv: got %b/%b want 0/0", ooo[1].rob.valid, ooo[1].rat.valid); end
    idle_inputs();
    dispatch_count = 2'd2;
    step();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL underflow_count: got %0d want 0", count); end
    step();
    checks++; if (count !== 4'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL underflow_empty: got %0d/%b want 0/1", count, in_ready); end
  endtask

  task automatic test_full();
    reset = 1'b0;
    #3;
    reset = 1'b1;
    dispatch_count = 2'd0;
    for (int k = 0; k < 3; k++) begin
      if_id[0] = mk_lane(1'b1, mk_addi(2*k+1), 32'h0);
      if_id[1] = mk_lane(1'b1, mk_addi(2*k+2), 32'h0);
      step();
      checks++; if (count !== 4'(2*k+2) || in_ready !== 1'b1) begin errors++; $display("FAIL fill_%0d: got %0d/%b want %0d/1", k, count, in_ready, 2*k+2); end
    end
    if_id[0] = mk_lane(1'b1, mk_addi(7), 32'h0);
    if_id[1] = mk_lane(1'b0, mk_addi(0), 32'h0);
    step();
    checks++; if (count !== 4'd7 || in_ready !== 1'b0) begin errors++; $display("FAIL full_7: got %0d/%b want 7/0", count, in_ready); end
    if_id[0] = mk_lane(1'b1, mk_addi(8), 32'h0);
    if_id[1] = mk_lane(1'b1, mk_addi(9), 32'h0);
    step();
    step();
    checks++; if (count !== 4'd7 || in_ready !== 1'b0) begin errors++; $display("FAIL full_hold: got %0d/%b want 7/0", count, in_ready); end
    checks++; if (ooo[0].rs.dest_arn !== 5'd1 || ooo[1].rs.dest_arn !== 5'd2) begin errors++; $display("FAIL full_head: got %0d,%0d want 1,2", ooo[0].rs.dest_arn, ooo[1].rs.dest_arn); end
    idle_inputs();
  endtask

  task automatic test_wrap();
    dispatch_count = 2'd2;
    step();
    checks++; if (count !== 4'd5 || in_ready !== 1'b1 || ooo[0].rs.dest_arn !== 5'd3) begin errors++; $display("FAIL wrap_pre1: got %0d/%b/%0d want 5/1/3", count, in_ready, ooo[0].rs.dest_arn); end
    step();
    checks++; if (count !== 4'd3 || ooo[0].rs.dest_arn !== 5'd5 || ooo[1].rs.dest_arn !== 5'd6) begin errors++; $display("FAIL wrap_pre2: got %0d/%0d/%0d want 3/5/6", count, ooo[0].rs.dest_arn, ooo[1].rs.dest_arn); end
    if_id[0] = mk_lane(1'b1, mk_addi(10), 32'h0);
    if_id[1] = mk_lane(1'b1, mk_addi(11), 32'h0);
    dispatch_count = 2'd2;
    step();
    checks++; if (count !== 4'd3) begin errors++; $display("FAIL wrap_count: got %0d want 3", count); end
    checks++; if (ooo[0].rs.dest_arn !== 5'd7 || ooo[1].rs.dest_arn !== 5'd10) begin errors++; $display("FAIL wrap_head: got %0d,%0d want 7,10", ooo[0].rs.dest_arn, ooo[1].rs.dest_arn); end
    idle_inputs();
    dispatch_count = 2'd1;
    step();
    checks++; if (count !== 4'd2 || ooo[0].rs.dest_arn !== 5'd10 || ooo[1].rs.dest_arn !== 5'd11) begin errors++; $display("FAIL wrap_order: got %0d/%0d,%0d want 2/10,11", count, ooo[0].rs.dest_arn, ooo[1].rs.dest_arn); end
  endtask

  task automatic test_squash();
    dispatch_count = 2'd0;
    if_id[0] = mk_lane(1'b1, mk_addi(12), 32'h0);
    if_id[1] = mk_lane(1'b1, mk_addi(13), 32'h0);
    step();
    if_id[0] = mk_lane(1'b1, mk_addi(14), 32'h0);
    if_id[1] = mk_lane(1'b0, mk_addi(0), 32'h0);
    step();
    checks++; if (count !== 4'd5) begin errors++; $display("FAIL squash_pre: got %0d want 5", count); end
    squash = 1'b1;
    if_id[0] = mk_lane(1'b1, mk_addi(15), 32'h0);
    if_id[1] = mk_lane(1'b1, mk_addi(16), 32'h0);
    dispatch_count = 2'd2;
    step();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL squash_count: got %0d want 0", count); end
    checks++; if ({ooo[1].rs.valid, ooo[0].rs.valid} !== 2'b00 || in_ready !== 1'b1) begin errors++; $display("FAIL squash_out: got %b/%b want 00/1", {ooo[1].rs.valid, ooo[0].rs.valid}, in_ready); end
    squash = 1'b0;
    dispatch_count = 2'd0;
    if_id[0] = mk_lane(1'b1, mk_addi(20), 32'h0);
    if_id[1] = mk_lane(1'b1, mk_addi(21), 32'h0);
    step();
    checks++; if (count !== 4'd2 || ooo[0].rs.dest_arn !== 5'd20 || ooo[1].rs.dest_arn !== 5'd21) begin errors++; $display("FAIL squash_after: got %0d/%0d,%0d want 2/20,21", count, ooo[0].rs.dest_arn, ooo[1].rs.dest_arn); end
  endtask

  task automatic test_back_to_back();
    if_id[0] = mk_lane(1'b1, 32'h1050_0073, 32'h200);  // wfi (halt)
    if_id[1] = mk_lane(1'b1, 32'h0053_2423, 32'h204);  // sw x5, 8(x6)
    dispatch_count = 2'd2;
    step();
    checks++; if (count !== 4'd2) begin errors++; $display("FAIL b2b_count: got %0d want 2", count); end
    checks++; if (ooo[0].rs.halt !== 1'b1 || ooo[0].rob.halt !== 1'b1) begin errors++; $display("FAIL halt_flag: got %b/%b want 1/1", ooo[0].rs.halt, ooo[0].rob.halt); end
    checks++; if (ooo[0].rs.op1_arn !== 5'd0 || ooo[0].rs.op2_arn !== 5'd0 || ooo[0].rs.dest_arn !== 5'd0) begin errors++; $display("FAIL halt_regs: got %0d/%0d/%0d want 0/0/0", ooo[0].rs.op1_arn, ooo[0].rs.op2_arn, ooo[0].rs.dest_arn); end
    checks++; if (ooo[1].rs.wr_mem !== 1'b1 || ooo[1].rs.imm !== 32'd8) begin errors++; $display("FAIL store_ctl: got %b/%0d want 1/8", ooo[1].rs.wr_mem, ooo[1].rs.imm); end
    checks++; if (ooo[1].rs.op1_arn !== 5'd6 || ooo[1].rs.op2_arn !== 5'd5 || ooo[1].rs.dest_arn !== 5'd0) begin errors++; $display("FAIL store_regs: got %0d/%0d/%0d want 6/5/0", ooo[1].rs.op1_arn, ooo[1].rs.op2_arn, ooo[1].rs.dest_arn); end
    if_id[0] = mk_lane(1'b1, 32'hFFFF_FFFF, 32'h208);
    if_id[1] = mk_lane(1'b0, 32'h0, 32'h0);
    step();
    checks++; if (count !== 4'd1 || ooo[0].rob.illegal !== 1'b1 || ooo[0].rob.pc !== 32'h208) begin errors++; $display("FAIL illegal: got %0d/%b/%h want 1/1/208", count, ooo[0].rob.illegal, ooo[0].rob.pc); end
  endtask

  task automatic test_reset_midstream();
    dispatch_count = 2'd0;
    if_id[0] = mk_lane(1'b1, mk_addi(3), 32'h0);
    if_id[1] = mk_lane(1'b1, mk_addi(4), 32'h0);
    step();
    checks++; if (count !== 4'd3) begin errors++; $display("FAIL mid_pre: got %0d want 3", count); end
    #3;
    reset = 1'b0;
    #1;
    checks++; if (count !== 4'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL mid_async: got %0d/%b want 0/1", count, in_ready); end
    checks++; if ({ooo[1].rs.valid, ooo[0].rs.valid} !== 2'b00) begin errors++; $display("FAIL mid_valid: got %b want 00", {ooo[1].rs.valid, ooo[0].rs.valid}); end
    step();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL mid_held: got %0d want 0", count); end
    idle_inputs();
    #2;
    reset = 1'b1;
    if_id[0] = mk_lane(1'b1, mk_addi(30), 32'h0);
    step();
    checks++; if (count !== 4'd1 || ooo[0].rs.dest_arn !== 5'd30) begin errors++; $display("FAIL mid_resume: got %0d/%0d want 1/30", count, ooo[0].rs.dest_arn); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b0;
    squash = 1'b0;
    dispatch_count = 2'd0;
    idle_inputs();
    test_reset();
    test_basic();
    test_sparse();
    test_full();
    test_wrap();
    test_squash();
    test_back_to_back();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stage_decode_queue.md
STAGE_DECODE_QUEUE -- requirements
Module: stage_decode_queue

Interface
REQ-001 SHALL have parameter N, default `N, meaning decode/dispatch width in instructions per cycle.
REQ-002 SHALL have parameter DEPTH, default 16, meaning queue capacity in decoded entries; legal range DEPTH >= 2*N.
REQ-003 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port squash  input  1  flushes all queued entries (branch mispredict or exception).
REQ-006 SHALL have port if_id_packet  input  IF_ID_PACKET[N]  fetched lanes, each with its own valid bit; valid lanes may be non-contiguous.
REQ-007 SHALL have port in_ready  output  1  the block accepts this cycle's if_id_packet.
REQ-008 SHALL have port dispatch_count  input  $clog2(N+1)  number of head entries downstream consumes this cycle.
REQ-009 SHALL have port id_ooo_packet  output  ID_OOO_PACKET  the N oldest decoded entries, with rs/rob/rat fields and per-lane valid bits.
REQ-010 SHALL have port count  output  $clog2(DEPTH+1)  current occupancy.

Function
REQ-011 SHALL decode each input lane combinationally at enqueue and store the decoded record; no decode at the output.
REQ-012 SHALL assert in_ready iff registered count <= DEPTH-N; same-cycle dequeue does not raise in_ready.
REQ-013 SHALL, when in_ready=1 and squash=0, enqueue the valid lanes only, compacted in lane order (lowest lane oldest), at tail.
REQ-014 SHALL, when in_ready=0, drop nothing: upstream holds if_id_packet, and no lane is enqueued.
REQ-015 SHALL drive output lane i from entry (head+i) mod DEPTH, with valid[i] = (i < count); fields of invalid lanes are don't-care, but rob/rat valid SHALL be 0.
REQ-016 SHALL dequeue min(dispatch_count, count, N) entries per cycle; it clamps an excessive dispatch_count silently.
REQ-017 SHALL update count as count + enq - deq in one cycle when enqueue and dequeue coincide.
REQ-018 SHALL wrap head and tail modulo DEPTH for any DEPTH, including non-powers of two.
REQ-019 SHALL, on squash=1, set head=tail=count=0 at the next edge and ignore that cycle's enqueue and dequeue.
REQ-020 SHALL keep the stage_decode operand rules: op1_arn and op2_arn are ZERO_REG for halt or unused operands, and dest_arn is ZERO_REG when there is no destination.
REQ-021 SHALL latch entries for halt or illegal instructions like any other entry; the ROB handles them.
REQ-022 SHALL have a latency of 1 cycle from enqueue to visibility on id_ooo_packet.

Reset
REQ-023 SHALL, while reset=0, force head=0, tail=0 and count=0 asynchronously, giving in_ready=1 and all output valid bits 0.
REQ-024 SHALL leave the entry storage contents unreset; they are masked by count.
REQ-025 SHALL abandon any in-flight enqueue or dequeue when reset is asserted mid-operation.

Structure
REQ-026 SHALL place a DECODED_INST typedef (ID_RS_PACKET, ROB_ENTRY and RAT input fields) and the `DQ_DEPTH default in sys_defs.svh.
REQ-027 SHALL instantiate the existing decoder sub-module once per input lane; there are no other sub-modules.
REQ-028 SHALL implement compaction as a prefix-sum over the input valid bits.

Verification
REQ-029 SHALL cover this case: after reset, N=2, DEPTH=8, lanes {valid,valid} with addi x1 and add x2 -> next cycle count=2, out valid=11, dest_arn 1,2.
REQ-030 SHALL cover this case: lanes {invalid,valid} -> one entry enqueued, lands in output lane 0, count=1.
REQ-031 SHALL cover this case: fill to 7 with dispatch_count=0 -> in_ready=0 at count 7, input held, count stays 7.
REQ-032 SHALL cover this case: count=3, enqueue 2 with dispatch_count=2 -> count=3, head advanced by 2, and order preserved across the wrap at index 7->0.
REQ-033 SHALL cover this case: count=5, squash with a valid enqueue -> count=0, outputs invalid next cycle, in_ready=1.
REQ-034 SHALL cover this case: dispatch_count=2 with count=1 -> count=0, no underflow; reset low mid-stream -> count=0 immediately, without waiting for a clock edge.
